// File: rtl/gray_conv_scheduler.sv
// Round-robin scheduler feeding a bit-serial gray-to-binary converter.
// One requester is served at a time; the result is held until acknowledged.
module gray_conv_scheduler #(
  parameter  int WIDTH = 4,
  parameter  int NREQ  = 4,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] gray_in,
  output logic [NREQ-1:0]       grant,
  output logic                  busy,
  output logic                  bin_valid,
  output logic [WIDTH-1:0]      bin_out,
  output logic [IDW-1:0]        bin_id,
  input  logic                  bin_ack
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t                      state;
  logic [IDW-1:0]              ptr, win_id, pick;
  logic                        pick_ok;
  logic [NREQ-1:0]             rot;
  logic [IDW:0]                sum;
  logic [NREQ-1:0][WIDTH-1:0]  gray_w;
  logic [WIDTH-1:0]            gsh, bsh;
  logic                        carry, bit_now;
  logic [CW-1:0]               cnt;

  assign gray_w  = gray_in;
  assign busy    = (state != IDLE);
  assign bit_now = carry ^ gsh[WIDTH-1];

  // Rotate requests so bit 0 is the pointer position, take the first set bit.
  always_comb begin
    rot     = NREQ'({req, req} >> ptr);
    pick    = '0;
    pick_ok = 1'b0;
    sum     = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!pick_ok && rot[i]) begin
        pick_ok = 1'b1;
        sum     = {1'b0, ptr} + (IDW+1)'(i);
        if (sum >= (IDW+1)'(NREQ)) sum = sum - (IDW+1)'(NREQ);
        pick    = sum[IDW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      win_id    <= '0;
      grant     <= '0;
      bin_valid <= 1'b0;
      bin_out   <= '0;
      bin_id    <= '0;
      gsh       <= '0;
      bsh       <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: if (pick_ok) begin
          gsh    <= gray_w[pick];
          bsh    <= '0;
          carry  <= 1'b0;
          cnt    <= '0;
          grant  <= NREQ'(1) << pick;
          win_id <= pick;
          state  <= CONV;
        end
        CONV: begin
          // MSB of the shifted gray word meets the running binary bit.
          gsh   <= gsh << 1;
          carry <= bit_now;
          bsh   <= {bsh[WIDTH-2:0], bit_now};
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(WIDTH-1)) begin
            bin_out   <= WIDTH'({bsh, bit_now});
            bin_id    <= win_id;
            bin_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: if (bin_ack) begin
          bin_valid <= 1'b0;
          grant     <= '0;
          ptr       <= (win_id == IDW'(NREQ-1)) ? '0 : win_id + IDW'(1);
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/gray_conv_scheduler.md
GRAY_CONV_SCHEDULER -- requirements
Module: gray_conv_scheduler

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the gray/binary word width (WIDTH >= 2).
REQ-002 Parameter NREQ, default 4, SHALL set the number of requesters (NREQ >= 2); IDW = clog2(NREQ).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 req  input  NREQ  SHALL carry one conversion request per requester, level-sensitive.
REQ-006 gray_in  input  NREQ*WIDTH  SHALL carry the packed gray words; requester k uses bits [k*WIDTH +: WIDTH].
REQ-007 grant  output  NREQ  SHALL be a one-hot registered grant to the requester being served, or all-zero.
REQ-008 busy  output  1  SHALL be high whenever the state is not IDLE.
REQ-009 bin_valid  output  1  SHALL flag a completed result, held until acknowledged.
REQ-010 bin_out  output  WIDTH  SHALL carry the registered binary result.
REQ-011 bin_id  output  IDW  SHALL carry the index of the requester that owns bin_out.
REQ-012 bin_ack  input  1  SHALL acknowledge and release the result.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, CONV, DONE.
REQ-014 In IDLE with req != 0, the block SHALL pick the winner round-robin, searching upward from pointer ptr and wrapping modulo NREQ.
REQ-015 On that IDLE cycle, the winner's gray word SHALL be latched, grant set one-hot to the winner, the winner index stored, and the state set to CONV.
REQ-016 In IDLE with req == 0, the block SHALL remain in IDLE with all outputs unchanged.
REQ-017 CONV SHALL last exactly WIDTH cycles and resolve one bit per cycle, MSB first.
REQ-018 The bit step SHALL be b[WIDTH-1] = g[WIDTH-1], then b[i] = b[i+1] XOR g[i] for i from WIDTH-2 down to 0, using a 1-bit carry register cleared on entry to CONV.
REQ-019 On the last CONV cycle, the block SHALL load the full result into bin_out, load the stored index into bin_id, set bin_valid = 1, and go to DONE.
REQ-020 Latency: with a request accepted in IDLE at cycle t, bin_valid SHALL first be high at cycle t+WIDTH+1.
REQ-021 In DONE, bin_valid, bin_out, bin_id and grant SHALL stay stable until a cycle with bin_ack = 1.
REQ-022 On a DONE cycle with bin_ack = 1, the next cycle SHALL have state IDLE, bin_valid = 0, grant = 0 and ptr = (winner+1) mod NREQ.
REQ-023 bin_out and bin_id SHALL hold their last value after the acknowledge.
REQ-024 bin_ack SHALL be ignored outside DONE.
REQ-025 Changes on req and gray_in during CONV and DONE SHALL be ignored; a conversion always completes on the latched word, even if the winner deasserts req.
REQ-026 New requests SHALL be accepted only in IDLE, so the minimum grant-to-grant period is WIDTH+2 cycles when bin_ack is returned on the first DONE cycle.
REQ-027 A requester that holds req continuously SHALL be served again only after every other active requester has been served once (no starvation).

Reset
REQ-028 With rst = 1 at a clock edge, the next cycle SHALL have state IDLE, ptr = 0, grant = 0, busy = 0, bin_valid = 0, bin_out = 0, bin_id = 0 and the carry and shift registers = 0.
REQ-029 Reset SHALL take priority over every other event, including mid-CONV and mid-DONE; an aborted conversion SHALL produce no bin_valid.

Verification (WIDTH=4, NREQ=4)
REQ-030 Single request: req=0001, gray word 1100, bin_ack tied high -> grant=0001 from t+1, bin_valid at t+5, bin_out=1000, bin_id=0, then IDLE at t+6.
REQ-031 Conversion table on requester 2: gray 0011/0101/1010/1111 -> bin_out 0010/0110/1100/1010, bin_id=2 each time.
REQ-032 Fairness: req=1111 held, bin_ack high -> grant sequence 0001, 0010, 0100, 1000, 0001 at a 6-cycle period.
REQ-033 Backpressure: bin_ack low for 10 cycles in DONE, req=1111 -> bin_valid, bin_out and grant constant for all 10 cycles, no new grant; release follows the first bin_ack cycle.
REQ-034 Reset mid-CONV: rst at the second CONV cycle -> all outputs zero next cycle; then req=1010 -> grant=0010 (ptr restored to 0).
REQ-035 Withdrawal: winner drops req and gray_in changes on the first CONV cycle -> the result still matches the latched word and bin_valid still arrives at t+5.
